serial_subtractor: RTL

- Bit-serial N-bit subtractor: computes Data_in_A - Data_in_B - Data_in_Borrow one bit per clock, LSB first.
- Uses a single full-subtractor bit slice and a borrow flip-flop.
- It is the inverse-operation counterpart to the team's ripple full-adder datapath, for area-constrained lab designs where one slice is reused over WIDTH cycles.
- Start/Busy/Done handshake to a controlling FSM or testbench.

---
 rtl/serial_arith_pkg.sv | 13 +
 rtl/full_subtractor_bit.sv | 19 +
 rtl/serial_subtractor.sv | 96 +++++++++
 3 files changed

// File: rtl/serial_arith_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks (subtractor now,
// adder later): FSM encoding and default operand width.
package serial_arith_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/full_subtractor_bit.sv
// One-bit full subtractor: Diff = A - B - Bin, Bout set when the bit underflows.
// Two half-subtractor stages; either stage borrowing produces the borrow-out.
module full_subtractor_bit (
  input  logic A,
  input  logic B,
  input  logic Bin,
  output logic Diff,
  output logic Bout
);

  logic d1, b1, b2;

  assign d1   = A ^ B;
  assign b1   = ~A & B;
  assign Diff = d1 ^ Bin;
  assign b2   = ~d1 & Bin;
  assign Bout = b1 | b2;

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor: A - B - Borrow, one bit per clock LSB first,
// reusing a single full-subtractor slice and a borrow flip-flop.
module serial_subtractor
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Start,
  input  logic [WIDTH-1:0] Data_in_A,
  input  logic [WIDTH-1:0] Data_in_B,
  input  logic             Data_in_Borrow,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Data_out_Diff,
  output logic             Data_out_Borrow
);

  localparam int CW = $clog2(WIDTH + 1);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sr, b_sr, d_sr, d_nxt;
  logic             bor_ff;
  logic [CW-1:0]    cnt;
  logic             d, bnext, last;

  full_subtractor_bit u_slice (
    .A    (a_sr[0]),
    .B    (b_sr[0]),
    .Bin  (bor_ff),
    .Diff (d),
    .Bout (bnext)
  );

  // Difference bits enter at the MSB so the LSB lands at bit 0 after WIDTH shifts.
  generate
    if (WIDTH == 1) begin : g_w1
      assign d_nxt = d;
    end else begin : g_wn
      assign d_nxt = {d, d_sr[WIDTH-1:1]};
    end
  endgenerate

  assign last = (cnt == CW'(WIDTH - 1));

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (Start) state_nxt = SHIFT;
      SHIFT:   if (last)  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      a_sr            <= '0;
      b_sr            <= '0;
      d_sr            <= '0;
      bor_ff          <= 1'b0;
      cnt             <= '0;
      Data_out_Diff   <= '0;
      Data_out_Borrow <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (Start) begin
          a_sr   <= Data_in_A;
          b_sr   <= Data_in_B;
          bor_ff <= Data_in_Borrow;
          cnt    <= '0;
        end
        SHIFT: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          d_sr   <= d_nxt;
          bor_ff <= bnext;
          cnt    <= cnt + 1'b1;
          if (last) begin
            Data_out_Diff   <= d_nxt;
            Data_out_Borrow <= bnext;
          end
        end
        default: ;
      endcase
    end
  end

  // Both are decodes of the state register, so Start never reaches them combinationally.
  assign Busy = (state == SHIFT) || (state == DONE);
  assign Done = (state == DONE);

endmodule
